// File: rtl/ifetch_unit.sv
// Instruction fetch unit: producer side of the fetch->decode interface.
// Issues single-outstanding word reads to instruction memory, buffers the
// returned words with their PCs in a small FIFO, and presents the oldest one
// (with PC+8) to decode. A branch redirect flushes the buffer and any
// in-flight read, then fetch restarts at the target.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   imem_req/imem_addr  registered read request and word-aligned address
//   imem_ack/imem_rdata one-cycle acknowledge with read data
//   stall               decode is not consuming this cycle
//   redirect/redirect_pc branch taken and its target
//   InstrF/PCPlus8      head instruction and its PC+8 (NOP / 0 when invalid)
//   InstrValidF         InstrF holds a real fetched instruction
module ifetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] InstrF,
    output logic [31:0] PCPlus8,
    output logic        InstrValidF
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t        state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic          req_d;
    logic [31:0]   addr_d;
    entry_t        fifo_q [DEPTH];
    entry_t        head;
    logic          push, pop;
    logic [31:0]   target;
    logic [CW-1:0] post_push;

    // Decode-facing view of the FIFO head; redirect masks validity at once
    always_comb begin
        target      = redirect_pc & 32'hFFFF_FFFC;
        head        = fifo_q[rd_ptr_q];
        InstrValidF = (count_q != '0) && !redirect;
        pop         = InstrValidF && !stall;
        InstrF      = InstrValidF ? head.instr : NOP_INSTR;
        PCPlus8     = InstrValidF ? (head.pc + 32'd8) : 32'h0;
    end

    // Request FSM next-state, fetch PC and request outputs
    always_comb begin
        state_d   = state_q;
        fpc_d     = fpc_q;
        req_d     = imem_req;
        addr_d    = imem_addr;
        push      = 1'b0;
        post_push = count_q + CW'(1) - CW'(pop);

        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    fpc_d = target;
                end else if (count_q < DEPTH_C) begin
                    state_d = WAIT;
                    req_d   = 1'b1;
                    addr_d  = fpc_q;
                end
            end
            WAIT: begin
                if (redirect) begin
                    // An unacked read must still be drained before reissuing
                    fpc_d   = target;
                    req_d   = 1'b0;
                    state_d = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    push  = 1'b1;
                    fpc_d = fpc_q + 32'd4;
                    // Keep streaming only if the next ack still has a free slot
                    if (post_push < DEPTH_C) begin
                        addr_d = fpc_q + 32'd4;
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            DROP: begin
                if (redirect) begin
                    fpc_d = target;
                end
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        if (redirect) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            fpc_q     <= RESET_PC;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            state_q   <= state_d;
            fpc_q     <= fpc_d;
            count_q   <= count_d;
            imem_req  <= req_d;
            imem_addr <= addr_d;
            if (redirect) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // FIFO storage; contents are qualified by count so need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= entry_t'{pc: fpc_q, instr: imem_rdata};
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: a behavioural memory with variable
// ack latency, directed scenarios followed by random stall/redirect traffic,
// and a negedge monitor that checks every cycle against a stream-level model.
module tb_ifetch_unit;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'hE1A0_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] InstrF;
    logic [31:0] PCPlus8;
    logic        InstrValidF;

    int errors = 0;
    int checks = 0;

    // Memory behaviour controls
    int mem_lat  = 0;
    bit lat_rand = 1'b0;

    // Redirect targets issued by stimulus, consumed by the monitor
    logic [31:0] seg_q [$];
    int delivered = 0;
    int valid_run = 0;

    ifetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .InstrF     (InstrF),
        .PCPlus8    (PCPlus8),
        .InstrValidF(InstrValidF)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic bit cond(input int which);
        case (which)
            0:       return imem_req;
            1:       return imem_req && !imem_ack;
            2:       return imem_req && imem_ack;
            default: return InstrValidF;
        endcase
    endfunction

    task automatic wait_sig(input string name, input int which, input int max_cycles);
        int n = 0;
        while (!cond(which) && n < max_cycles) begin
            tick();
            n++;
        end
        chk(name, 32'(cond(which)), 32'd1);
    endtask

    task automatic do_redirect(input logic [31:0] t);
        redirect    = 1'b1;
        redirect_pc = t;
        seg_q.push_back(t);
        tick();
        redirect = 1'b0;
    endtask

    // Instruction memory: accepts one request, acks after mem_lat cycles
    initial begin
        bit          pending = 1'b0;
        int          wait_cnt = 0;
        logic [31:0] p_addr = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            if (!pending && imem_req) begin
                pending  = 1'b1;
                p_addr   = imem_addr;
                wait_cnt = lat_rand ? int'($urandom_range(0, 3)) : mem_lat;
            end
            if (pending) begin
                if (wait_cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = word_at(p_addr);
                    pending    = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Monitor: head PC of the expected stream and next expected fetch address
    initial begin
        logic [31:0] exp_pc;
        logic [31:0] fetch_exp;
        logic [31:0] buffered;
        logic [31:0] t;
        exp_pc    = RESET_PC;
        fetch_exp = RESET_PC;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_valid", 32'(InstrValidF), 32'd0);
                chk("rst_instr", InstrF, NOP);
                chk("rst_pcplus8", PCPlus8, 32'h0);
                chk("rst_req", 32'(imem_req), 32'd0);
                chk("rst_addr", imem_addr, RESET_PC);
                exp_pc    = RESET_PC;
                fetch_exp = RESET_PC;
                valid_run = 0;
            end else begin
                buffered = (fetch_exp - exp_pc) >> 2;
                chk("valid", 32'(InstrValidF), 32'((buffered != 0) && !redirect));
                if (InstrValidF) begin
                    chk("instr", InstrF, word_at(exp_pc));
                    chk("pcplus8", PCPlus8, exp_pc + 32'd8);
                    valid_run++;
                end else begin
                    chk("nop_instr", InstrF, NOP);
                    chk("nop_pcplus8", PCPlus8, 32'h0);
                    valid_run = 0;
                end
                if (imem_req) begin
                    chk("fetch_addr", imem_addr, fetch_exp);
                    chk("slot_reserved", 32'(buffered < DEPTH), 32'd1);
                end
                if (redirect) begin
                    if (seg_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL seg_q: redirect with no recorded target at %0t", $time);
                    end else begin
                        t         = seg_q.pop_front();
                        exp_pc    = t;
                        fetch_exp = t;
                    end
                end else begin
                    if (InstrValidF && !stall) begin
                        exp_pc = exp_pc + 32'd4;
                        delivered++;
                    end
                    if (imem_ack && imem_req) fetch_exp = fetch_exp + 32'd4;
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [31:0] tgt;
        repeat (3) tick();
        rst_n = 1'b1;

        // Zero-wait streaming: one instruction per cycle once filled
        repeat (28) tick();
        chk("throughput_run", 32'(valid_run >= 20), 32'd1);

        // Held stall: buffer fills and requests stop
        stall = 1'b1;
        repeat (5) tick();
        chk("stall_req_low", 32'(imem_req), 32'd0);
        chk("stall_valid", 32'(InstrValidF), 32'd1);
        stall = 1'b0;
        repeat (6) tick();

        // Redirect during an unacked read with 3-cycle memory
        mem_lat = 3;
        repeat (2) tick();
        wait_sig("wait_unacked", 1, 20);
        do_redirect(32'h0000_0100);
        chk("drop_req_low", 32'(imem_req), 32'd0);
        wait_sig("req_after_drop", 0, 20);
        chk("target_addr", imem_addr, 32'h0000_0100);
        wait_sig("first_valid", 3, 40);
        chk("target_instr", InstrF, word_at(32'h0000_0100));
        chk("target_pcplus8", PCPlus8, 32'h0000_0108);

        // Redirect coincident with the ack that would fill the FIFO
        stall = 1'b1;
        do_redirect(32'h0000_0300);
        wait_sig("ack_one", 2, 30);
        tick();
        wait_sig("ack_two", 2, 30);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0400;
        seg_q.push_back(32'h0000_0400);
        #1;
        chk("redir_mask", 32'(InstrValidF), 32'd0);
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        #1;
        chk("flushed_empty", 32'(InstrValidF), 32'd0);
        wait_sig("req_after_flush", 0, 10);
        chk("flush_target", imem_addr, 32'h0000_0400);
        repeat (10) tick();

        // Asynchronous reset while a read is outstanding
        wait_sig("wait_for_reset", 1, 20);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_req", 32'(imem_req), 32'd0);
        chk("async_addr", imem_addr, RESET_PC);
        chk("async_valid", 32'(InstrValidF), 32'd0);
        chk("async_instr", InstrF, NOP);
        chk("async_pcplus8", PCPlus8, 32'h0);
        repeat (6) tick();
        rst_n = 1'b1;
        wait_sig("req_after_reset", 0, 10);
        chk("reset_pc_addr", imem_addr, RESET_PC);
        repeat (8) tick();

        // Address wrap at the top of the address space
        mem_lat = 0;
        do_redirect(32'hFFFF_FFF8);
        repeat (12) tick();

        // Random stall / redirect / latency traffic
        lat_rand = 1'b1;
        for (int i = 0; i < 600; i++) begin
            stall = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 19) == 0) begin
                tgt = ($urandom_range(0, 3) == 0)
                      ? (32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2))
                      : ($urandom & 32'hFFFF_FFFC);
                redirect    = 1'b1;
                redirect_pc = tgt;
                seg_q.push_back(tgt);
            end else begin
                redirect    = 1'b0;
                redirect_pc = $urandom;
            end
            tick();
        end
        redirect = 1'b0;
        stall    = 1'b0;
        repeat (10) tick();
        chk("progress", 32'(delivered > 100), 32'd1);
        chk("targets_consumed", 32'(seg_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Fetch stage of the pipelined ARM core; the producer side of the fetch→decode instruction interface.
- Issues word reads to instruction memory over a req/ack handshake and buffers the returned words in a small FIFO.
- Presents the oldest buffered instruction, plus its PC+8, to the decode stage; decode consumes one per cycle unless it stalls.
- On a branch redirect, discards the buffer and any in-flight read, then fetches from the target.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, prefetch FIFO entries (power of two, ≥2).
- NOP_INSTR, 32'hE1A0_0000, instruction driven on InstrF when no valid instruction is available (MOV r0,r0).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  word-aligned read address; bits [1:0] always 0.
- imem_ack  in  1  one-cycle pulse; imem_rdata valid in the same cycle.
- imem_rdata  in  32  instruction word read from memory.
- stall  in  1  decode stage is not consuming this cycle.
- redirect  in  1  branch taken; flush and refetch.
- redirect_pc  in  32  branch target, sampled when redirect=1.
- InstrF  out  32  head-of-FIFO instruction, or NOP_INSTR when invalid.
- PCPlus8  out  32  PC of InstrF + 8; 32'h0 when invalid.
- InstrValidF  out  1  InstrF holds a real fetched instruction.

Behaviour:
- Internal state: fetch PC fpc, FIFO of {pc, instr} with count 0..DEPTH, and a request FSM with states IDLE, WAIT, DROP.
- Reset (async, while reset=0): fpc=RESET_PC, count=0, FSM=IDLE, imem_req=0, imem_addr=RESET_PC, InstrValidF=0, InstrF=NOP_INSTR, PCPlus8=0. Reset mid-transaction abandons the request; memory must tolerate an ack that is not followed by a new req.
- Issue rule: at most one request outstanding. A request is issued only when count + (FSM==WAIT) < DEPTH, so the ack always has a reserved slot.
- IDLE: if not redirect and the issue rule holds, go to WAIT with imem_req=1 and imem_addr=fpc (registered outputs).
- WAIT: imem_req and imem_addr are held stable until imem_ack.
  - On ack without redirect: push {fpc, imem_rdata}; fpc += 4.
  - After that ack, if the post-push count plus the pop this cycle leaves space, stay in WAIT with the new address (back-to-back, one instruction per cycle peak); otherwise go to IDLE and drop imem_req.
- Redirect in WAIT:
  - Without ack that cycle: go to DROP, drop imem_req, and set fpc=redirect_pc.
  - With ack that cycle: discard imem_rdata, set fpc=redirect_pc, go to IDLE.
- DROP: wait for imem_ack, discard its data, go to IDLE. A further redirect while in DROP updates fpc only.
- Redirect (any state): count=0 next cycle, and InstrValidF=0 in the redirect cycle itself (combinationally masked). The first fetch to the target is issued no earlier than the cycle after redirect (or after the DROP ack).
- Output: InstrValidF = (count≠0) & ~redirect. InstrF and PCPlus8 come from the FIFO head, else NOP_INSTR and 0.
- Pop when InstrValidF & ~stall; the head advances with pointer wrap mod DEPTH.
- Simultaneous push and pop: count is unchanged, the ordering of the remaining entries is preserved, and a push into a full FIFO cannot occur because of the issue rule.
- Arithmetic: fpc and PCPlus8 are 32-bit and wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).

Test Plan:
- Reset, zero-wait memory (ack the cycle after req), stall=0 → after the pipeline fills, addresses 0,4,8,… issued one per cycle; InstrValidF=1 every cycle with InstrF=mem[0],mem[4],… and PCPlus8=8,12,….
- stall=1 held for 5 cycles → at most DEPTH words buffered, imem_req low once count=2, InstrF stable; release → mem[N], mem[N+4] delivered in order with no loss or duplication.
- Memory with 3-cycle ack latency, redirect=1, redirect_pc=32'h100 during WAIT → FSM goes to DROP; stale ack data never appears on InstrF; next imem_addr=32'h100, and the first valid output is InstrF=mem[0x100] with PCPlus8=32'h108.
- redirect coincident with imem_ack and a full FIFO → InstrValidF=0 that cycle, FIFO empty next cycle, ack data dropped, next request to redirect_pc.
- Assert reset low while a request is outstanding (WAIT) → outputs immediately at reset values; after release, the first request goes to RESET_PC and the late ack is ignored.
- Start at fpc=32'hFFFF_FFF8 → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; PCPlus8 for the 32'hFFFF_FFFC instruction = 32'h0000_0004.
